// File: rtl/clint_timer.sv
// Core-local timer and software-interrupt source: 64-bit mtime/mtimecmp plus msip
// behind a word-wide slave port, with registered level interrupt outputs.
module clint_timer #(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              timer_int,
    output logic              software_int
);

    localparam logic [15:0]       DIV_MAX  = 16'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] OFF_MSIP = ADDR_W'(16'h0000);
    localparam logic [ADDR_W-1:0] OFF_CMPL = ADDR_W'(16'h4000);
    localparam logic [ADDR_W-1:0] OFF_CMPH = ADDR_W'(16'h4004);
    localparam logic [ADDR_W-1:0] OFF_MTL  = ADDR_W'(16'hBFF8);
    localparam logic [ADDR_W-1:0] OFF_MTH  = ADDR_W'(16'hBFFC);

    logic [15:0]       prescaler;
    logic [63:0]       mtime;
    logic [63:0]       mtimecmp;
    logic              msip;
    logic              tick;
    logic              wr;
    logic              rd;
    logic [ADDR_W-3:0] word;
    logic              sel_msip, sel_cmpl, sel_cmph, sel_mtl, sel_mth;
    logic [31:0]       rd_val;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, addr[1:0]};

    assign word     = addr[ADDR_W-1:2];
    assign sel_msip = (word == OFF_MSIP[ADDR_W-1:2]);
    assign sel_cmpl = (word == OFF_CMPL[ADDR_W-1:2]);
    assign sel_cmph = (word == OFF_CMPH[ADDR_W-1:2]);
    assign sel_mtl  = (word == OFF_MTL[ADDR_W-1:2]);
    assign sel_mth  = (word == OFF_MTH[ADDR_W-1:2]);

    assign wr   = req & we;
    assign rd   = req & ~we;
    assign tick = (prescaler == DIV_MAX);

    always_comb begin
        rd_val = '0;
        if (sel_msip)      rd_val = {31'd0, msip};
        else if (sel_cmpl) rd_val = mtimecmp[31:0];
        else if (sel_cmph) rd_val = mtimecmp[63:32];
        else if (sel_mtl)  rd_val = mtime[31:0];
        else if (sel_mth)  rd_val = mtime[63:32];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            mtime     <= '0;
            mtimecmp  <= '1;
            msip      <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 16'd1;

            // A write to either mtime half suppresses the whole increment this cycle.
            if (wr && sel_mtl)
                mtime[31:0] <= wdata;
            else if (wr && sel_mth)
                mtime[63:32] <= wdata;
            else if (tick)
                mtime <= mtime + 64'd1;

            if (wr && sel_cmpl) mtimecmp[31:0]  <= wdata;
            if (wr && sel_cmph) mtimecmp[63:32] <= wdata;
            if (wr && sel_msip) msip            <= wdata[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata        <= '0;
            ready        <= 1'b0;
            timer_int    <= 1'b0;
            software_int <= 1'b0;
        end else begin
            ready        <= req;
            if (rd) rdata <= rd_val;
            timer_int    <= (mtime >= mtimecmp);
            software_int <= msip;
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: two instances (TICK_DIV=1 and 4) share one bus and are
// compared every cycle against a 64-bit arithmetic model, plus literal pins.
module tb_clint_timer;

    typedef struct {
        logic [63:0]  mtime;
        logic [63:0]  cmp;
        logic         msip;
        int unsigned  presc;
        logic [31:0]  rdata;
        logic         ready;
        logic         tint;
        logic         sint;
    } model_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata0, rdata1;
    logic        ready0, ready1, tint0, tint1, sint0, sint1;

    model_t m0, m1;
    bit     armed = 1'b0;
    int     checks = 0;
    int     passed = 0;

    always #5 clk = ~clk;

    clint_timer #(.TICK_DIV(1), .ADDR_W(16)) dut0 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .ready(ready0), .timer_int(tint0), .software_int(sint0)
    );

    clint_timer #(.TICK_DIV(4), .ADDR_W(16)) dut1 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .ready(ready1), .timer_int(tint1), .software_int(sint1)
    );

    function automatic logic [31:0] read_reg(model_t s, logic [15:0] a);
        case ({a[15:2], 2'b00})
            16'h0000: return {31'd0, s.msip};
            16'h4000: return s.cmp[31:0];
            16'h4004: return s.cmp[63:32];
            16'hBFF8: return s.mtime[31:0];
            16'hBFFC: return s.mtime[63:32];
            default:  return 32'd0;
        endcase
    endfunction

    function automatic model_t step(model_t s, int unsigned div, logic rst, logic rq,
                                    logic w, logic [15:0] a, logic [31:0] d);
        model_t n = s;
        logic [15:0] off = {a[15:2], 2'b00};
        logic t;
        if (rst) begin
            n.mtime = 64'd0; n.cmp = {64{1'b1}}; n.msip = 1'b0; n.presc = 0;
            n.rdata = 32'd0; n.ready = 1'b0; n.tint = 1'b0; n.sint = 1'b0;
            return n;
        end
        t = (s.presc == div - 1);
        n.presc = t ? 0 : s.presc + 1;
        n.ready = rq;
        n.tint  = (s.mtime >= s.cmp);
        n.sint  = s.msip;
        if (rq && !w) n.rdata = read_reg(s, a);
        if (rq && w && off == 16'hBFF8)      n.mtime = {s.mtime[63:32], d};
        else if (rq && w && off == 16'hBFFC) n.mtime = {d, s.mtime[31:0]};
        else if (t)                          n.mtime = s.mtime + 64'd1;
        if (rq && w && off == 16'h4000) n.cmp[31:0]  = d;
        if (rq && w && off == 16'h4004) n.cmp[63:32] = d;
        if (rq && w && off == 16'h0000) n.msip = d[0];
        return n;
    endfunction

    always @(posedge clk) begin
        m0 <= step(m0, 1, reset, req, we, addr, wdata);
        m1 <= step(m1, 4, reset, req, we, addr, wdata);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check("ready0", 64'(ready0), 64'(m0.ready));
            check("rdata0", 64'(rdata0), 64'(m0.rdata));
            check("tint0",  64'(tint0),  64'(m0.tint));
            check("sint0",  64'(sint0),  64'(m0.sint));
            check("ready1", 64'(ready1), 64'(m1.ready));
            check("rdata1", 64'(rdata1), 64'(m1.rdata));
            check("tint1",  64'(tint1),  64'(m1.tint));
            check("sint1",  64'(sint1),  64'(m1.sint));
        end
    end

    task automatic bus(input logic w, input logic [15:0] a, input logic [31:0] d);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready0), 64'd0);
        check("rst_rdata", 64'(rdata0), 64'd0);
        check("rst_tint",  64'(tint0),  64'd0);
        check("rst_sint",  64'(sint1),  64'd0);
        armed = 1'b1;
        reset = 1'b0;

        repeat (100) @(negedge clk);
        bus(1'b0, 16'hBFF8, 0);
        check("idle_mtime_div1", 64'(rdata0), 64'd100);
        check("idle_mtime_div4", 64'(rdata1), 64'd25);

        bus(1'b1, 16'hBFFC, 0);
        bus(1'b1, 16'hBFF8, 0);
        bus(1'b1, 16'h4004, 0);
        bus(1'b1, 16'h4000, 20);
        for (int i = 0; i < 200 && !tint1; i++) @(negedge clk);
        check("tint1_rise", 64'(tint1), 64'd1);
        bus(1'b1, 16'h4000, 40);
        @(negedge clk);
        check("tint1_fall", 64'(tint1), 64'd0);

        bus(1'b1, 16'h0000, 32'hFFFF_FFFF);
        check("sint_lag", 64'(sint0), 64'd0);
        @(negedge clk);
        check("sint_set", 64'(sint0), 64'd1);
        bus(1'b0, 16'h0000, 0);
        check("msip_read", 64'(rdata0), 64'd1);
        bus(1'b1, 16'h0000, 0);
        @(negedge clk);
        check("sint_clr", 64'(sint0), 64'd0);

        bus(1'b1, 16'hBFF8, 32'h10);
        bus(1'b0, 16'hBFF8, 0);
        check("tick_collide", 64'(rdata0), 64'h10);

        bus(1'b0, 16'h1234, 0);
        check("unmapped_ready", 64'(ready0), 64'd1);
        check("unmapped_rdata", 64'(rdata0), 64'd0);

        req = 1'b1; we = 1'b0; addr = 16'h4000;
        @(negedge clk);
        check("b2b_ready_a", 64'(ready0), 64'd1);
        check("b2b_rdata_a", 64'(rdata0), 64'd40);
        addr = 16'h4004;
        @(negedge clk);
        req = 1'b0;
        check("b2b_ready_b", 64'(ready0), 64'd1);
        check("b2b_rdata_b", 64'(rdata0), 64'd0);

        bus(1'b1, 16'h4004, 32'hFFFF_FFFF);
        bus(1'b1, 16'h4000, 0);
        bus(1'b1, 16'hBFFC, 32'hFFFF_FFFF);
        bus(1'b1, 16'hBFF8, 32'hFFFF_FFFE);
        @(negedge clk);
        bus(1'b0, 16'hBFF8, 0);
        check("wrap_lo_ff", 64'(rdata0), 64'hFFFF_FFFF);
        check("wrap_tint_hi", 64'(tint0), 64'd1);
        bus(1'b0, 16'hBFFC, 0);
        check("wrap_hi_zero", 64'(rdata0), 64'd0);
        check("wrap_tint_lo", 64'(tint0), 64'd0);

        reset = 1'b1; req = 1'b1; we = 1'b1; addr = 16'h0000; wdata = 1;
        @(negedge clk);
        check("rstacc_ready0", 64'(ready0), 64'd0);
        check("rstacc_ready1", 64'(ready1), 64'd0);
        check("rstacc_tint", 64'(tint0), 64'd0);
        reset = 1'b0; req = 1'b0; we = 1'b0;
        @(negedge clk);
        check("rstacc_sint", 64'(sint0), 64'd0);
        bus(1'b0, 16'h4000, 0);
        check("rstacc_cmpl", 64'(rdata0), 64'hFFFF_FFFF);
        bus(1'b0, 16'h4004, 0);
        check("rstacc_cmph", 64'(rdata1), 64'hFFFF_FFFF);

        for (int i = 0; i < 600; i++) begin
            logic [15:0] a;
            case ($urandom_range(0, 5))
                0: a = 16'h0000;
                1: a = 16'h4000;
                2: a = 16'h4004;
                3: a = 16'hBFF8;
                4: a = 16'hBFFC;
                default: a = 16'($urandom);
            endcase
            reset = ($urandom_range(0, 60) == 0);
            req   = $urandom_range(0, 1);
            we    = $urandom_range(0, 1);
            addr  = a | 16'($urandom_range(0, 3));
            wdata = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 300));
            @(negedge clk);
        end
        reset = 1'b0; req = 1'b0; we = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
